aes_vector_sequencer: RTL and testbench

//  Sequences AES known-answer / side-channel runs: pulls one vector from the test-vector generator,

---
 rtl/aes_vector_sequencer_pkg.sv | 21 ++
 rtl/aes_vector_sequencer_timer.sv | 28 ++
 rtl/aes_vector_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_vector_sequencer_pkg.sv
// AES vector sequencer shared definitions: FSM state encoding and
// a width helper for the shared phase timer.
package aes_vector_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ARM,
        S_RUN,
        S_RESULT,
        S_GAP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/aes_vector_sequencer_timer.sv
// Loadable down-counter shared by the ARM, RUN-timeout and GAP phases.
// Ports: clk, reset (async, high), load+value (preset), tick (count), zero.
module aes_vector_sequencer_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         tick,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/aes_vector_sequencer.sv
// Sequences AES known-answer / side-channel runs: fetch vector, load
// core, trigger scope, start, wait done, present result, quiet gap.
// Ports: clk/reset, start/stop control, gen_* vector generator link,
// aes_* core link, res_* valid/ready result port, trig/busy/status.
module aes_vector_sequencer
    import aes_vector_sequencer_pkg::*;
#(
    parameter int KEY_W       = 128,
    parameter int NUM_VECTORS = 128,
    parameter int REPEAT      = 1,
    parameter int TRIG_PRE    = 4,
    parameter int TIMEOUT     = 1024,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    output logic                           gen_ena,
    input  logic [127:0]                   gen_plain,
    input  logic [KEY_W-1:0]               gen_key,
    output logic [127:0]                   aes_plain,
    output logic [KEY_W-1:0]               aes_key,
    output logic                           aes_start,
    input  logic                           aes_done,
    input  logic [127:0]                   aes_cipher,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [127:0]                   res_cipher,
    output logic [$clog2(NUM_VECTORS)-1:0] res_idx,
    output logic [$clog2(REPEAT+1)-1:0]    res_rep,
    output logic                           trig,
    output logic                           busy,
    output logic                           done_all,
    output logic                           timeout_err
);

    localparam int VW = $clog2(NUM_VECTORS);
    localparam int RW = $clog2(REPEAT + 1);
    localparam int TW = $clog2(max3(TRIG_PRE, TIMEOUT, GAP_CYCLES) + 1);

    localparam logic [VW-1:0] VEC_LAST = VW'(NUM_VECTORS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

    // Timer presets are "cycles minus one": zero marks the last cycle.
    localparam logic [TW-1:0] T_ARM = TW'((TRIG_PRE > 0) ? TRIG_PRE - 1 : 0);
    localparam logic [TW-1:0] T_RUN = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_GAP = TW'(GAP_CYCLES - 1);

    state_t          state;
    state_t          state_n;
    logic            stop_lat;
    logic [VW-1:0]   vec_idx;
    logic [RW-1:0]   rep_cnt;
    logic            tmr_load;
    logic            tmr_tick;
    logic [TW-1:0]   tmr_val;
    logic            tmr_zero;
    logic            rep_last;
    logic            vec_last;
    logic            gap_end;
    logic            vec_adv;
    logic            rep_inc;
    logic            run_to;

    assign rep_last = (rep_cnt == REP_LAST);
    assign vec_last = (vec_idx == VEC_LAST);
    assign gap_end  = (state == S_GAP) && tmr_zero;
    // A vector is finished once its last repeat clears GAP, whether
    // the exit is a stop or a normal advance.
    assign vec_adv  = gap_end && rep_last;
    assign rep_inc  = gap_end && !stop_lat && !rep_last;
    assign run_to   = (state == S_RUN) && !aes_done && tmr_zero;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_n = (TRIG_PRE == 0) ? S_RUN : S_ARM;
            end
            S_ARM: begin
                if (tmr_zero) state_n = S_RUN;
            end
            S_RUN: begin
                if (aes_done) state_n = S_RESULT;
                else if (tmr_zero) state_n = S_GAP;
            end
            S_RESULT: begin
                if (res_ready) state_n = S_GAP;
            end
            S_GAP: begin
                if (tmr_zero) begin
                    if (stop_lat) state_n = S_IDLE;
                    else if (!rep_last)
                        state_n = (TRIG_PRE == 0) ? S_RUN : S_ARM;
                    else if (vec_last) state_n = S_IDLE;
                    else state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tmr_val = '0;
        unique case (state_n)
            S_ARM:   tmr_val = T_ARM;
            S_RUN:   tmr_val = T_RUN;
            S_GAP:   tmr_val = T_GAP;
            default: tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_n != state);
    assign tmr_tick = !tmr_load;

    aes_vector_sequencer_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .tick  (tmr_tick),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // Control outputs are flops decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            stop_lat  <= 1'b0;
            gen_ena   <= 1'b0;
            aes_start <= 1'b0;
            trig      <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            gen_ena   <= (state_n == S_FETCH);
            aes_start <= (state_n == S_RUN) && (state != S_RUN);
            trig      <= (state_n == S_ARM) || (state_n == S_RUN);
            res_valid <= (state_n == S_RESULT);
            busy      <= (state_n != S_IDLE);
            // A stop seen in IDLE alongside start carries into the run.
            if (state_n == S_IDLE) stop_lat <= 1'b0;
            else if (stop) stop_lat <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aes_plain   <= '0;
            aes_key     <= '0;
            res_cipher  <= '0;
            res_idx     <= '0;
            res_rep     <= '0;
            vec_idx     <= '0;
            rep_cnt     <= '0;
            done_all    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_CAPTURE) begin
                aes_plain <= gen_plain;
                aes_key   <= gen_key;
                rep_cnt   <= '0;
            end else if (rep_inc) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
            if (state == S_RUN && aes_done) begin
                res_cipher <= aes_cipher;
                res_idx    <= vec_idx;
                res_rep    <= rep_cnt;
            end
            if (vec_adv) begin
                vec_idx <= vec_last ? '0 : vec_idx + 1'b1;
            end
            if (state == S_IDLE && start) begin
                done_all    <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (vec_adv && vec_last) done_all <= 1'b1;
                if (run_to) timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Self-checking bench for aes_vector_sequencer: scenario table with
// stub generator/core/sink, reference result queue, reset sequences.
module tb_aes_vector_sequencer;

    localparam int NV   = 4;
    localparam int REP  = 2;
    localparam int TP   = 3;
    localparam int TO   = 30;
    localparam int GAPC = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic         gen_ena;
    logic [127:0] gen_plain;
    logic [127:0] gen_key;
    logic [127:0] aes_plain;
    logic [127:0] aes_key;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_cipher;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_cipher;
    logic [1:0]   res_idx;
    logic [1:0]   res_rep;
    logic         trig;
    logic         busy;
    logic         done_all;
    logic         timeout_err;

    aes_vector_sequencer #(
        .KEY_W       (128),
        .NUM_VECTORS (NV),
        .REPEAT      (REP),
        .TRIG_PRE    (TP),
        .TIMEOUT     (TO),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .gen_ena     (gen_ena),
        .gen_plain   (gen_plain),
        .gen_key     (gen_key),
        .aes_plain   (aes_plain),
        .aes_key     (aes_key),
        .aes_start   (aes_start),
        .aes_done    (aes_done),
        .aes_cipher  (aes_cipher),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_cipher  (res_cipher),
        .res_idx     (res_idx),
        .res_rep     (res_rep),
        .trig        (trig),
        .busy        (busy),
        .done_all    (done_all),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int hold;
        int stop_at;
        int n_res;
        int n_gen;
        bit done_all;
        bit terr;
    } scen_t;

    typedef struct {
        logic [127:0] c;
        int           idx;
        int           rep;
    } res_t;

    res_t         expq[$];
    scen_t        tbl[10];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           rel, first_gen, first_start;
    int           n_res, n_gen, n_start;
    int           lat, hold, stop_at, cd, vcnt, trig_len;
    int           gen_cnt = 0;
    int           mg = 0;
    int           m_idx = 0;
    bit           pend, done_acc, force_done, gen_flag;
    logic [127:0] held;

    function automatic logic [127:0] pf(input int g);
        return {32'(g) * 32'h9E3779B9, ~32'(g),
                32'(g) ^ 32'hA5A5A5A5, 32'(g) + 32'd7};
    endfunction

    function automatic logic [127:0] kf(input int g);
        return {32'(g) + 32'h1000, 32'(g) * 32'd5,
                32'hC0DE0000 | 32'(g), 32'(g) * 32'd3 + 32'd1};
    endfunction

    function automatic logic [127:0] cf(input logic [127:0] p,
                                       input logic [127:0] k);
        return p ^ {k[63:0], k[127:64]}
                 ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of the stub generator, core and result sink.
    task automatic step();
        res_t e;
        @(negedge clk);
        rel++;
        stop = 1'b0;
        if (gen_flag) begin
            gen_plain = pf(gen_cnt);
            gen_key   = kf(gen_cnt);
            gen_flag  = 1'b0;
        end
        if (gen_ena) begin
            gen_cnt++;
            n_gen++;
            gen_flag = 1'b1;
            if (first_gen < 0) first_gen = rel;
        end
        if (done_acc) chk("trig_after_done", trig, 0);
        done_acc = 1'b0;
        aes_done = 1'b0;
        if (aes_start) begin
            chk("trig_at_start", trig, 1);
            chk("trig_pre_len", trig_len, TP);
            chk("core_plain", aes_plain, pf(gen_cnt));
            chk("core_key", aes_key, kf(gen_cnt));
            n_start++;
            if (first_start < 0) first_start = rel;
            if (n_start - 1 == stop_at) stop = 1'b1;
            pend = 1'b1;
            cd   = lat;
        end
        if (!trig || aes_start) trig_len = 0;
        else trig_len++;
        if (pend && lat >= 0) begin
            if (cd == 0) begin
                aes_done   = 1'b1;
                aes_cipher = cf(aes_plain, aes_key);
                pend       = 1'b0;
                done_acc   = (lat < TO);
            end else begin
                cd--;
            end
        end
        if (force_done) begin
            aes_done   = 1'b1;
            aes_cipher = '1;
        end
        if (res_valid) begin
            if (vcnt > 0) chk("res_stable", res_cipher, held);
            else held = res_cipher;
            if (vcnt < hold) begin
                res_ready = 1'b0;
                vcnt++;
            end else begin
                res_ready = 1'b1;
                n_res++;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL res_extra: got idx %0d, expected none",
                             res_idx);
                end else begin
                    e = expq.pop_front();
                    chk("res_cipher", res_cipher, e.c);
                    chk("res_idx", res_idx, e.idx);
                    chk("res_rep", res_rep, e.rep);
                end
            end
        end else begin
            vcnt      = 0;
            res_ready = (hold == 0);
        end
    endtask

    // Reference: walk vectors/repeats in order, one fetch per vector.
    task automatic model(input scen_t s);
        int  v;
        int  e;
        int  se;
        bit  fin;
        bit  to;
        v   = m_idx;
        e   = 0;
        fin = 1'b0;
        se  = (s.stop_at == -2) ? 0 : s.stop_at;
        to  = (s.lat < 0) || (s.lat >= TO);
        while (!fin) begin
            mg++;
            for (int r = 0; r < REP; r++) begin
                if (!to) expq.push_back('{cf(pf(mg), kf(mg)), v, r});
                if (e == se) begin
                    fin = 1'b1;
                    if (r == REP - 1) v = (v + 1) % NV;
                    break;
                end
                e++;
            end
            if (!fin) begin
                v++;
                if (v == NV) begin
                    v   = 0;
                    fin = 1'b1;
                end
            end
        end
        m_idx = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t s;
        int    k;
        start      = 1'b0;
        stop       = 1'b0;
        gen_plain  = '0;
        gen_key    = '0;
        aes_done   = 1'b0;
        aes_cipher = '0;
        res_ready  = 1'b1;
        pend       = 1'b0;
        done_acc   = 1'b0;
        force_done = 1'b0;
        gen_flag   = 1'b0;
        vcnt       = 0;
        trig_len   = 0;
        hold       = 0;
        lat        = -1;
        stop_at    = -1;
        n_start    = 0;
        n_res      = 0;
        n_gen      = 0;
        first_gen  = -1;
        first_start = -1;
        rel        = 0;

        tbl[0] = '{10, 0, -1, 8, 4, 1'b1, 1'b0};
        tbl[1] = '{0,  0, -1, 8, 4, 1'b1, 1'b0};
        tbl[2] = '{3,  0,  2, 3, 2, 1'b0, 1'b0};
        tbl[3] = '{7,  0,  1, 2, 1, 1'b0, 1'b0};
        tbl[4] = '{4, 20, -1, 4, 2, 1'b1, 1'b0};
        tbl[5] = '{35, 0, -1, 0, 4, 1'b1, 1'b1};
        tbl[6] = '{29, 3, -1, 8, 4, 1'b1, 1'b0};
        tbl[7] = '{1,  0, -2, 1, 1, 1'b0, 1'b0};
        for (int i = 8; i < 10; i++) begin
            int l;
            l = int'($urandom_range(0, TO + 4));
            tbl[i] = '{l, int'($urandom_range(0, 5)), -1,
                       (l < TO) ? NV * REP : 0, NV, 1'b1, l >= TO};
        end

        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset_outputs",
            {gen_ena, aes_start, res_valid, trig, busy, done_all,
             timeout_err, |aes_plain, |aes_key, |res_cipher,
             |res_idx, |res_rep}, 0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            s = tbl[i];
            lat = s.lat;
            hold = s.hold;
            stop_at = s.stop_at;
            pend = 1'b0;
            n_res = 0;
            n_gen = 0;
            n_start = 0;
            first_gen = -1;
            first_start = -1;
            model(s);
            step();
            start = 1'b1;
            if (stop_at == -2) stop = 1'b1;
            rel = 0;
            step();
            start = 1'b0;
            k = 0;
            while (busy && k < 4000) begin
                step();
                k++;
            end
            chk($sformatf("s%0d_busy_end", i), busy, 0);
            chk($sformatf("s%0d_n_res", i), n_res, s.n_res);
            chk($sformatf("s%0d_n_gen", i), n_gen, s.n_gen);
            chk($sformatf("s%0d_done_all", i), done_all, s.done_all);
            chk($sformatf("s%0d_timeout_err", i), timeout_err, s.terr);
            chk($sformatf("s%0d_missing_res", i), expq.size(), 0);
            chk($sformatf("s%0d_gen_latency", i), first_gen, 1);
            chk($sformatf("s%0d_start_latency", i), first_start, 3 + TP);
            expq.delete();
        end

        // Async reset in the middle of RUN, then a stray done pulse.
        lat = -1;
        hold = 0;
        stop_at = -1;
        pend = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!aes_start && k < 50) begin
            step();
            k++;
        end
        chk("mid_reset_reached_run", aes_start, 1);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_outputs",
            {gen_ena, aes_start, res_valid, trig, busy, done_all,
             timeout_err, |aes_plain, |aes_key, |res_cipher,
             |res_idx, |res_rep}, 0);
        step();
        reset = 1'b0;
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_idle",
                {res_valid, busy, trig, aes_start, gen_ena}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
